shift_unit_seq: RTL and testbench

//   Parametrised, handshaked shift/rotate unit for the ALU datapath; successor to the 4-bit
//   one-step shifter. Accepts WIDTH-bit operand + shift amount + mode over valid/ready, shifts

---
 rtl/shift_unit_seq_pkg.sv | 36 +++
 rtl/shift_unit_seq_step.sv | 54 +++++
 rtl/shift_unit_seq.sv | 205 ++++++++++++++++++++
 tb/tb_shift_unit_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_unit_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_unit_seq_pkg
//   Shared definitions for the shift/rotate unit and anything that talks to it:
//   mode codes, FSM state encoding and small mode-classification helpers.
//   Used by shift_step, shift_unit_seq and the ALU top / benches.
// -----------------------------------------------------------------------------
package shift_unit_seq_pkg;

    localparam int unsigned MODE_W = 3;

    // Operation codes carried on in_mode; 5..7 are reserved (pass-through).
    typedef enum logic [MODE_W-1:0] {
        SHIFT_LSL = 3'd0,
        SHIFT_LSR = 3'd1,
        SHIFT_ASR = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Shifts saturate their step count at WIDTH.
    function automatic logic mode_is_shift(input logic [MODE_W-1:0] m);
        return (m == SHIFT_LSL) || (m == SHIFT_LSR) || (m == SHIFT_ASR);
    endfunction

    // Rotates use the raw shift amount (result wraps modulo WIDTH).
    function automatic logic mode_is_rotate(input logic [MODE_W-1:0] m);
        return (m == SHIFT_ROL) || (m == SHIFT_ROR);
    endfunction

endpackage

// File: rtl/shift_unit_seq_step.sv
// -----------------------------------------------------------------------------
// shift_step
//   Combinational one-bit shift/rotate step (generalised 4-bit shifter).
//   Ports:
//     d       in   WIDTH   current operand
//     mode    in   3       operation code (shift_mode_e); reserved codes pass d
//     fill    in   1       bit entering LSB (LSL) or MSB (LSR)
//     d_next  out  WIDTH   operand after one step
//     bucket  out  1       bit leaving this step (0 for reserved codes)
// -----------------------------------------------------------------------------
module shift_step
    import shift_unit_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  d,
    input  logic [MODE_W-1:0] mode,
    input  logic              fill,
    output logic [WIDTH-1:0]  d_next,
    output logic              bucket
);

    always_comb begin
        d_next = d;
        bucket = 1'b0;
        case (mode)
            SHIFT_LSL: begin
                d_next = {d[WIDTH-2:0], fill};
                bucket = d[WIDTH-1];
            end
            SHIFT_LSR: begin
                d_next = {fill, d[WIDTH-1:1]};
                bucket = d[0];
            end
            SHIFT_ASR: begin
                d_next = {d[WIDTH-1], d[WIDTH-1:1]};
                bucket = d[0];
            end
            SHIFT_ROL: begin
                d_next = {d[WIDTH-2:0], d[WIDTH-1]};
                bucket = d[WIDTH-1];
            end
            SHIFT_ROR: begin
                d_next = {d[0], d[WIDTH-1:1]};
                bucket = d[0];
            end
            default: begin
                d_next = d;
                bucket = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// -----------------------------------------------------------------------------
// shift_unit_seq
//   Handshaked shift/rotate unit. Accepts operand + amount + mode on in_*,
//   produces result, last bit shifted out (bucket) and zero flag on out_*.
//   Default build: iterative, one shift_step per clock.
//   Build option SHIFT_BARREL_EN: single-cycle cascade of shift_step stages,
//   every op completes IDLE->DONE with identical results.
//   Ports:
//     clk, rst_n            clock (rising), async active-low reset
//     in_valid / in_ready   request handshake (ready only in IDLE)
//     in_data, in_shamt     operand, shift amount
//     in_mode, in_fill      operation code, shift-in bit for LSL/LSR
//     out_valid / out_ready result handshake
//     out_data, out_bucket  result, last bit out (0 when no step)
//     out_zero              out_data == 0
//     busy                  FSM not in IDLE
// -----------------------------------------------------------------------------
module shift_unit_seq
    import shift_unit_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_mode,
    input  logic               in_fill,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_bucket,
    output logic               out_zero,
    output logic               busy
);

    // Shift saturation point; if WIDTH exceeds the amount range it can never hit.
    localparam int unsigned SAT_INT =
        (WIDTH < (1 << SHAMT_W)) ? WIDTH : ((1 << SHAMT_W) - 1);
    localparam logic [SHAMT_W-1:0] SAT_STEPS = SHAMT_W'(SAT_INT);

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   data_q,      data_d;
    logic               bucket_q,    bucket_d;
    logic               zero_q,      zero_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;
    logic               in_ready_q,  in_ready_d;

    logic [SHAMT_W-1:0] steps;
    logic               accept;

    assign accept = in_valid && in_ready_q;

    // Number of single-bit steps the request needs.
    always_comb begin
        if (mode_is_shift(in_mode)) begin
            steps = (in_shamt > SAT_STEPS) ? SAT_STEPS : in_shamt;
        end else if (mode_is_rotate(in_mode)) begin
            steps = in_shamt;
        end else begin
            steps = '0;
        end
    end

`ifdef SHIFT_BARREL_EN
    // One stage per possible step; stage i is bypassed when i >= steps so the
    // bucket of the last active stage propagates to the end.
    localparam int MAX_STEPS = (1 << SHAMT_W) - 1;

    logic [MAX_STEPS:0][WIDTH-1:0] cas_d;
    logic [MAX_STEPS:0]            cas_b;

    assign cas_d[0] = in_data;
    assign cas_b[0] = 1'b0;

    for (genvar i = 0; i < MAX_STEPS; i++) begin : g_stage
        localparam logic [SHAMT_W-1:0] IDX = SHAMT_W'(i);
        logic [WIDTH-1:0] stage_d;
        logic             stage_b;

        shift_step #(.WIDTH(WIDTH)) u_step (
            .d      (cas_d[i]),
            .mode   (in_mode),
            .fill   (in_fill),
            .d_next (stage_d),
            .bucket (stage_b)
        );

        assign cas_d[i+1] = (IDX < steps) ? stage_d : cas_d[i];
        assign cas_b[i+1] = (IDX < steps) ? stage_b : cas_b[i];
    end
`else
    logic [SHAMT_W-1:0] cnt_q,  cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   step_d;
    logic               step_b;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .d      (data_q),
        .mode   (mode_q),
        .fill   (fill_q),
        .d_next (step_d),
        .bucket (step_b)
    );
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        bucket_d = bucket_q;
        zero_d   = zero_q;
`ifndef SHIFT_BARREL_EN
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef SHIFT_BARREL_EN
                    data_d   = cas_d[MAX_STEPS];
                    bucket_d = cas_b[MAX_STEPS];
                    zero_d   = (cas_d[MAX_STEPS] == '0);
                    state_d  = ST_DONE;
`else
                    data_d   = in_data;
                    mode_d   = in_mode;
                    fill_d   = in_fill;
                    cnt_d    = steps;
                    bucket_d = 1'b0;
                    zero_d   = (in_data == '0);
                    state_d  = (steps == '0) ? ST_DONE : ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: begin
`ifdef SHIFT_BARREL_EN
                state_d  = ST_DONE;
`else
                data_d   = step_d;
                bucket_d = step_b;
                zero_d   = (step_d == '0);
                cnt_d    = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the next state.
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            bucket_q    <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
`ifndef SHIFT_BARREL_EN
            cnt_q       <= '0;
            mode_q      <= '0;
            fill_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            bucket_q    <= bucket_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
`ifndef SHIFT_BARREL_EN
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = data_q;
    assign out_bucket = bucket_q;
    assign out_zero   = zero_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
module tb_shift_unit_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // DUT A: WIDTH=8, SHAMT_W=4
    logic       a_in_valid, a_in_ready, a_in_fill, a_out_valid, a_out_ready;
    logic       a_out_bucket, a_out_zero, a_busy;
    logic [7:0] a_in_data, a_out_data;
    logic [3:0] a_in_shamt;
    logic [2:0] a_in_mode;

    // DUT B: WIDTH=4, SHAMT_W=3
    logic       b_in_valid, b_in_ready, b_in_fill, b_out_valid, b_out_ready;
    logic       b_out_bucket, b_out_zero, b_busy;
    logic [3:0] b_in_data, b_out_data;
    logic [2:0] b_in_shamt;
    logic [2:0] b_in_mode;

    shift_unit_seq #(.WIDTH(8), .SHAMT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_shamt(a_in_shamt), .in_mode(a_in_mode), .in_fill(a_in_fill),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_bucket(a_out_bucket), .out_zero(a_out_zero), .busy(a_busy)
    );

    shift_unit_seq #(.WIDTH(4), .SHAMT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_mode(b_in_mode), .in_fill(b_in_fill),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_bucket(b_out_bucket), .out_zero(b_out_zero), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int steps);
`ifdef SHIFT_BARREL_EN
        return 1;
`else
        return 1 + steps;
`endif
    endfunction

    // Waits until in_ready, drives one request, returns after the accept edge (+1).
    task automatic issue_a(input logic [7:0] d, input logic [3:0] sh, input logic [2:0] md,
                           input logic f);
        a_in_data = d; a_in_shamt = sh; a_in_mode = md; a_in_fill = f; a_in_valid = 1'b1;
        for (int w = 0; w < 20 && !a_in_ready; w++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_data  = ~d;                 // later input changes must not matter
        a_in_fill  = ~f;
        a_in_shamt = sh + 4'd1;
    endtask

    task automatic run_a(input string tag, input logic [7:0] d, input logic [3:0] sh,
                         input logic [2:0] md, input logic f, input logic [7:0] ed,
                         input logic eb, input logic ez, input int esteps, input int hold);
        int lat;
        issue_a(d, sh, md, f);
        lat = 1;
        while (!a_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"},    lat,          exp_lat(esteps));
        chk({tag, "_data"},   a_out_data,   ed);
        chk({tag, "_bucket"}, a_out_bucket, eb);
        chk({tag, "_zero"},   a_out_zero,   ez);
        for (int h = 0; h < hold; h++) begin
            a_in_valid = 1'b1; a_in_data = 8'hA5; a_in_shamt = 4'd0; a_in_mode = 3'd0;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, a_out_valid, 1'b1);
            chk({tag, "_hold_data"},  a_out_data,  ed);
            chk({tag, "_hold_bkt"},   a_out_bucket, eb);
            chk({tag, "_hold_rdy"},   a_in_ready,  1'b0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk({tag, "_post_valid"}, a_out_valid, 1'b0);
        chk({tag, "_post_rdy"},   a_in_ready,  1'b1);
        chk({tag, "_post_busy"},  a_busy,      1'b0);
    endtask

    // Reference for WIDTH=4: closed-form shift/rotate results.
    task automatic ref4(input int d, input int sh, input int md, input int f,
                        output int rd, output int rb, output int rn);
        int n, ones, k;
        rd = d; rb = 0; rn = 0;
        n = (sh > 4) ? 4 : sh;
        ones = (1 << n) - 1;
        k = sh % 4;
        case (md)
            0: begin
                rn = n;
                rd = ((d << n) | (f != 0 ? ones : 0)) & 15;
                rb = (n == 0) ? 0 : ((d >> (4 - n)) & 1);
            end
            1, 2: begin
                rn = n;
                rd = (d >> n) | ((md == 1 ? f != 0 : d[3] != 0) ? ((ones << (4 - n)) & 15) : 0);
                rb = (n == 0) ? 0 : ((d >> (n - 1)) & 1);
            end
            3: begin
                rn = sh;
                rd = ((d << k) | (d >> (4 - k))) & 15;
                rb = (sh == 0) ? 0 : (rd & 1);
            end
            4: begin
                rn = sh;
                rd = ((d >> k) | (d << (4 - k))) & 15;
                rb = (sh == 0) ? 0 : ((rd >> 3) & 1);
            end
            default: begin
                rn = 0; rd = d; rb = 0;
            end
        endcase
    endtask

    initial begin
        int rd, rb, rn, lat, hold;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_mode = '0; a_in_fill = 1'b0;
        a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_mode = '0; b_in_fill = 1'b0;
        b_out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  a_out_valid,  1'b0);
        chk("rst_data",   a_out_data,   8'h00);
        chk("rst_bucket", a_out_bucket, 1'b0);
        chk("rst_zero",   a_out_zero,   1'b0);
        chk("rst_busy",   a_busy,       1'b0);
        chk("rst_ready",  a_in_ready,   1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready",  a_in_ready,   1'b1);
        chk("rel_zero",   a_out_zero,   1'b0);

        // Directed vectors: tag, data, shamt, mode, fill, exp data, bucket, zero, steps, hold
        run_a("lsl3",  8'b1011_0011, 4'd3,  3'd0, 1'b1, 8'b1001_1111, 1'b1, 1'b0, 3, 0);
        run_a("asr2",  8'h90,        4'd2,  3'd2, 1'b0, 8'hE4,        1'b0, 1'b0, 2, 0);
        run_a("ror1",  8'h81,        4'd1,  3'd4, 1'b0, 8'hC0,        1'b1, 1'b0, 1, 0);
        run_a("lsr12", 8'hFF,        4'd12, 3'd1, 1'b0, 8'h00,        1'b1, 1'b1, 8, 0);
        run_a("lsl0",  8'h5A,        4'd0,  3'd0, 1'b1, 8'h5A,        1'b0, 1'b0, 0, 5);
        run_a("rsv6",  8'h3C,        4'd5,  3'd6, 1'b1, 8'h3C,        1'b0, 1'b0, 0, 0);
        run_a("lsrf",  8'h00,        4'd3,  3'd1, 1'b1, 8'hE0,        1'b0, 1'b0, 3, 0);
        run_a("rol8",  8'h96,        4'd8,  3'd3, 1'b0, 8'h96,        1'b0, 1'b0, 8, 0);

        // Reset during the third SHIFT cycle of a 5-step op
        issue_a(8'hFF, 4'd5, 3'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", a_out_valid, 1'b0);
        chk("abort_busy",  a_busy,      1'b0);
        chk("abort_ready", a_in_ready,  1'b0);
        chk("abort_data",  a_out_data,  8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_rel_ready", a_in_ready, 1'b1);
        run_a("rol9", 8'h01, 4'd9, 3'd3, 1'b0, 8'h02, 1'b0, 1'b0, 9, 0);

        // Exhaustive WIDTH=4 sweep with random result backpressure
        for (int md = 0; md < 8; md++) begin
            for (int f = 0; f < 2; f++) begin
                for (int sh = 0; sh < 8; sh++) begin
                    for (int d = 0; d < 16; d++) begin
                        ref4(d, sh, md, f, rd, rb, rn);
                        b_in_data = 4'(d); b_in_shamt = 3'(sh); b_in_mode = 3'(md);
                        b_in_fill = 1'(f); b_in_valid = 1'b1;
                        for (int w = 0; w < 20 && !b_in_ready; w++) begin @(posedge clk); #1; end
                        @(posedge clk); #1;
                        b_in_valid = 1'b0;
                        b_in_data  = ~4'(d);
                        b_in_fill  = ~1'(f);
                        lat = 1;
                        while (!b_out_valid && lat < 40) begin
                            b_out_ready = 1'($urandom_range(0, 1));
                            @(posedge clk); #1;
                            lat++;
                        end
                        b_out_ready = 1'b0;
                        chk($sformatf("b_lat_m%0d_f%0d_s%0d_d%0d", md, f, sh, d), lat, exp_lat(rn));
                        chk($sformatf("b_data_m%0d_f%0d_s%0d_d%0d", md, f, sh, d), b_out_data, rd);
                        chk($sformatf("b_bkt_m%0d_f%0d_s%0d_d%0d", md, f, sh, d), b_out_bucket, rb);
                        chk($sformatf("b_zero_m%0d_f%0d_s%0d_d%0d", md, f, sh, d), b_out_zero, rd == 0);
                        hold = $urandom_range(0, 2);
                        repeat (hold) @(posedge clk);
                        #1;
                        b_out_ready = 1'b1;
                        @(posedge clk); #1;
                        b_out_ready = 1'b0;
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
